// File: rtl/ps2_player_input_if.sv
// rtl/ps2_player_input_if.sv - PS/2 byte stream link between the receiver and ps2_player_input
//
// Purpose: carries one received scancode byte plus its one-cycle valid strobe.
// Signals:
//   ps2_byte        8  received scancode byte, meaningful only while ps2_byte_valid=1
//   ps2_byte_valid  1  one-cycle strobe, one per received byte
// Modports: master = PS/2 receiver side (drives), slave = decoder side (samples).
interface ps2_player_input_if;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;

  modport master (output ps2_byte, output ps2_byte_valid);
  modport slave  (input  ps2_byte, input  ps2_byte_valid);
endinterface

// File: rtl/ps2_player_input.sv
// rtl/ps2_player_input.sv - set-2 scancode decoder producing per-player movement and bomb signals
//
// Purpose: tracks E0/F0 prefixes, keeps a held bit per game key, resolves opposing
// directions and emits one-cycle bomb pulses for the bomberman datapath.
// Ports:
//   clock           in   1   system clock
//   reset           in   1   synchronous active-high reset (highest priority)
//   clear           in   1   releases all keys, FSM to IDLE, discards a same-cycle byte
//   ps2             slave    scancode byte + valid strobe
//   p1_/p2_xdir/xmov/ydir/ymov  out  movement, dir 1 = right/down
//   p1_bomb/p2_bomb out  1   one-cycle pulse on a fresh bomb-key make
//   key_state       out  10  held bits {p2_B,p2_R,p2_L,p2_D,p2_U,p1_B,p1_R,p1_L,p1_D,p1_U}
module ps2_player_input #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int TO_W           = 22
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  ps2_player_input_if.slave   ps2,
  output logic                p1_xdir,
  output logic                p1_xmov,
  output logic                p1_ydir,
  output logic                p1_ymov,
  output logic                p1_bomb,
  output logic                p2_xdir,
  output logic                p2_xmov,
  output logic                p2_ydir,
  output logic                p2_ymov,
  output logic                p2_bomb,
  output logic [9:0]          key_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] LP_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [TO_W-1:0] r_to_cnt;
  logic [TO_W-1:0] w_to_cnt_next;
  logic [9:0]      r_keys;
  logic [9:0]      w_keys_next;
  logic            w_apply;
  logic            w_is_make;
  logic            w_ext;
  logic [9:0]      w_mask;
  logic            w_p1_bomb_next;
  logic            w_p2_bomb_next;
  // Output register, bit order {p2: bomb,ymov,ydir,xmov,xdir, p1: bomb,ymov,ydir,xmov,xdir}
  logic [9:0]      r_out;
  logic [9:0]      w_out_next;

  // One-hot held-bit mask for a code; codes with the wrong extended-ness map to nothing.
  function automatic logic [9:0] key_mask(input logic [7:0] code, input logic ext);
    logic [9:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        8'h1D: m[0] = 1'b1;
        8'h1B: m[1] = 1'b1;
        8'h1C: m[2] = 1'b1;
        8'h23: m[3] = 1'b1;
        8'h29: m[4] = 1'b1;
        8'h5A: m[9] = 1'b1;
        default: m = '0;
      endcase
    end else begin
      case (code)
        8'h75: m[5] = 1'b1;
        8'h72: m[6] = 1'b1;
        8'h6B: m[7] = 1'b1;
        8'h74: m[8] = 1'b1;
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  // {ymov, ydir, xmov, xdir} from U, D, L, R held bits; opposing keys cancel.
  function automatic logic [3:0] move_bits(input logic u, input logic d,
                                           input logic l, input logic r);
    return {u ^ d, d & ~u, l ^ r, r & ~l};
  endfunction

  assign w_mask = key_mask(ps2.ps2_byte, w_ext);

  always_comb begin
    w_state_next   = r_state;
    w_to_cnt_next  = '0;
    w_apply        = 1'b0;
    w_is_make      = 1'b0;
    w_ext          = 1'b0;
    if (ps2.ps2_byte_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (ps2.ps2_byte == 8'hE0)      w_state_next = ST_EXT;
          else if (ps2.ps2_byte == 8'hF0) w_state_next = ST_BRK;
          else begin
            w_apply   = 1'b1;
            w_is_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (ps2.ps2_byte == 8'hF0)      w_state_next = ST_EXT_BRK;
          else if (ps2.ps2_byte == 8'hE0) w_state_next = ST_EXT;
          else begin
            w_apply      = 1'b1;
            w_is_make    = 1'b1;
            w_ext        = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_apply      = 1'b1;
          w_state_next = ST_IDLE;
        end
        default: begin
          w_apply      = 1'b1;
          w_ext        = 1'b1;
          w_state_next = ST_IDLE;
        end
      endcase
    end else if (r_state != ST_IDLE) begin
      // A prefix left dangling too long is dropped without touching any key.
      if (r_to_cnt == LP_TO_LAST) begin
        w_state_next = ST_IDLE;
      end else begin
        w_to_cnt_next = r_to_cnt + TO_W'(1);
      end
    end
  end

  always_comb begin
    w_keys_next    = r_keys;
    w_p1_bomb_next = 1'b0;
    w_p2_bomb_next = 1'b0;
    if (w_apply) begin
      if (w_is_make) begin
        w_keys_next    = r_keys | w_mask;
        // Typematic repeats find the bit already held and produce no pulse.
        w_p1_bomb_next = w_mask[4] & ~r_keys[4];
        w_p2_bomb_next = w_mask[9] & ~r_keys[9];
      end else begin
        w_keys_next = r_keys & ~w_mask;
      end
    end
    // Movement is computed from the next held bits so it lands with key_state.
    w_out_next = {w_p2_bomb_next,
                  move_bits(w_keys_next[5], w_keys_next[6], w_keys_next[7], w_keys_next[8]),
                  w_p1_bomb_next,
                  move_bits(w_keys_next[0], w_keys_next[1], w_keys_next[2], w_keys_next[3])};
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_state  <= ST_IDLE;
      r_to_cnt <= '0;
      r_keys   <= '0;
      r_out    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_to_cnt <= w_to_cnt_next;
      r_keys   <= w_keys_next;
      r_out    <= w_out_next;
    end
  end

  assign p1_xdir   = r_out[0];
  assign p1_xmov   = r_out[1];
  assign p1_ydir   = r_out[2];
  assign p1_ymov   = r_out[3];
  assign p1_bomb   = r_out[4];
  assign p2_xdir   = r_out[5];
  assign p2_xmov   = r_out[6];
  assign p2_ydir   = r_out[7];
  assign p2_ymov   = r_out[8];
  assign p2_bomb   = r_out[9];
  assign key_state = r_keys;

endmodule

// File: tb/tb_ps2_player_input.sv
// tb/tb_ps2_player_input.sv - self-checking bench for ps2_player_input
module tb_ps2_player_input;
  localparam int T = 32;

  logic clock;
  logic reset;
  logic clear;
  logic p1_xdir, p1_xmov, p1_ydir, p1_ymov, p1_bomb;
  logic p2_xdir, p2_xmov, p2_ydir, p2_ymov, p2_bomb;
  logic [9:0] key_state;

  ps2_player_input_if ifc ();

  ps2_player_input #(.TIMEOUT_CYCLES(T), .TO_W(6)) dut (
    .clock(clock), .reset(reset), .clear(clear), .ps2(ifc.slave),
    .p1_xdir(p1_xdir), .p1_xmov(p1_xmov), .p1_ydir(p1_ydir), .p1_ymov(p1_ymov),
    .p1_bomb(p1_bomb),
    .p2_xdir(p2_xdir), .p2_xmov(p2_xmov), .p2_ydir(p2_ydir), .p2_ymov(p2_ymov),
    .p2_bomb(p2_bomb),
    .key_state(key_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;
  int p1_pulses = 0;
  int p2_pulses = 0;

  // Behavioural model: held keys by name, pending prefix flags, idle gap since prefix.
  bit [9:0] m_keys = '0;
  bit m_b1 = 0, m_b2 = 0;
  bit m_ext_pend = 0, m_brk_pend = 0;
  int m_gap = 0;

  // Key table: index into held bits for (code, extended).
  function automatic int key_idx(input bit [7:0] b, input bit ext);
    bit [7:0] codes [10] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29,
                             8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};
    bit       exts  [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 10; i++)
      if (codes[i] == b && exts[i] == ext) return i;
    return -1;
  endfunction

  task automatic model_key(input bit [7:0] b, input bit ext, input bit make);
    int k;
    k = key_idx(b, ext);
    if (k < 0) return;
    if (make) begin
      if (k == 4 && !m_keys[4]) m_b1 = 1;
      if (k == 9 && !m_keys[9]) m_b2 = 1;
      m_keys[k] = 1;
    end else begin
      m_keys[k] = 0;
    end
  endtask

  task automatic model_edge(input bit v, input bit [7:0] b, input bit clr, input bit rst);
    m_b1 = 0;
    m_b2 = 0;
    if (rst || clr) begin
      m_keys = '0; m_ext_pend = 0; m_brk_pend = 0; m_gap = 0;
    end else if (v) begin
      m_gap = 0;
      if (m_brk_pend) begin
        model_key(b, m_ext_pend, 0);
        m_ext_pend = 0; m_brk_pend = 0;
      end else if (b == 8'hF0) begin
        m_brk_pend = 1;
      end else if (b == 8'hE0) begin
        m_ext_pend = 1;
      end else begin
        model_key(b, m_ext_pend, 1);
        m_ext_pend = 0;
      end
    end else if (m_ext_pend || m_brk_pend) begin
      m_gap++;
      if (m_gap >= T) begin
        m_ext_pend = 0; m_brk_pend = 0; m_gap = 0;
      end
    end
  endtask

  function automatic bit [9:0] expect_vec();
    bit u1, d1, l1, r1, u2, d2, l2, r2;
    {r1, l1, d1, u1} = m_keys[3:0];
    {r2, l2, d2, u2} = m_keys[8:5];
    return {m_b2, bit'(u2 != d2), bit'(d2 && !u2), bit'(l2 != r2), bit'(r2 && !l2),
            m_b1, bit'(u1 != d1), bit'(d1 && !u1), bit'(l1 != r1), bit'(r1 && !l1)};
  endfunction

  wire [9:0] dut_vec = {p2_bomb, p2_ymov, p2_ydir, p2_xmov, p2_xdir,
                        p1_bomb, p1_ymov, p1_ydir, p1_xmov, p1_xdir};

  always @(negedge clock) begin
    if (check_en) begin
      checks++;
      if (dut_vec !== expect_vec() || key_state !== m_keys) begin
        errors++;
        $display("FAIL cycle_compare t=%0t outputs=%b key_state=%b required outputs=%b key_state=%b",
                 $time, dut_vec, key_state, expect_vec(), m_keys);
      end
    end
  end

  task automatic expect_lit(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One clock: drive at negedge, model the posedge, return at the next negedge.
  task automatic step(input bit v, input bit [7:0] b, input bit clr, input bit rst);
    ifc.ps2_byte_valid = v;
    ifc.ps2_byte       = b;
    clear              = clr;
    reset              = rst;
    @(posedge clock);
    model_edge(v, b, clr, rst);
    @(negedge clock);
    if (p1_bomb === 1'b1) p1_pulses++;
    if (p2_bomb === 1'b1) p2_pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
  endtask

  task automatic send(input bit [7:0] b);
    step(1, b, 0, 0);
    idle(9);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0] pool [16] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B,
                            8'h74, 8'h5A, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1, 8'hAA};
    ifc.ps2_byte = 8'h00; ifc.ps2_byte_valid = 0; clear = 0; reset = 1;
    @(negedge clock);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    check_en = 1;
    expect_lit("reset_outputs", dut_vec, 10'h000);
    expect_lit("reset_key_state", key_state, 10'h000);
    idle(2);

    // P1 up then right, then release both.
    send(8'h1D);
    expect_lit("p1_up_ymov_ydir", {8'h0, p1_ymov, p1_ydir}, 10'b10);
    send(8'h23);
    expect_lit("p1_right_xmov_xdir", {8'h0, p1_xmov, p1_xdir}, 10'b11);
    expect_lit("p1_up_right_keys", key_state, 10'h009);
    send(8'hF0); send(8'h1D); send(8'hF0); send(8'h23);
    expect_lit("p1_released_outputs", dut_vec, 10'h000);
    expect_lit("p1_released_keys", key_state, 10'h000);

    // P2 left + right cancel; releasing left leaves right.
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74);
    expect_lit("p2_lr_cancel", {8'h0, p2_xmov, p2_xdir}, 10'b00);
    send(8'hE0); send(8'hF0); send(8'h6B);
    expect_lit("p2_right_only", {8'h0, p2_xmov, p2_xdir}, 10'b11);
    expect_lit("p2_right_p1_quiet", {5'h0, p1_bomb, p1_ymov, p1_ydir, p1_xmov, p1_xdir}, 10'h000);
    send(8'hE0); send(8'hF0); send(8'h74);

    // Typematic bomb: exactly two single-cycle pulses.
    p1_pulses = 0;
    send(8'h29); send(8'h29); send(8'h29); send(8'hF0); send(8'h29); send(8'h29);
    expect_lit("p1_bomb_pulse_count", 10'(p1_pulses), 10'd2);
    send(8'hF0); send(8'h29);

    // Non-extended 75 is not P2 up; Enter fires P2 bomb.
    send(8'h75);
    expect_lit("unprefixed_75_ignored", key_state, 10'h000);
    p2_pulses = 0;
    send(8'h5A);
    expect_lit("p2_bomb_pulse_count", 10'(p2_pulses), 10'd1);
    expect_lit("p2_bomb_held", {9'h0, key_state[9]}, 10'h001);
    send(8'hF0); send(8'h5A);

    // Dangling E0 times out, so the late 75 is a non-extended (unmapped) code.
    step(1, 8'hE0, 0, 0);
    idle(T);
    send(8'h75);
    expect_lit("timeout_p2_ymov", {9'h0, p2_ymov}, 10'h000);
    expect_lit("timeout_keys", key_state, 10'h000);

    // Clear beats a simultaneous F0; next 1D is a make.
    send(8'h1D); send(8'hE0); send(8'h72);
    expect_lit("pre_clear_keys", key_state, 10'h041);
    step(1, 8'hF0, 1, 0);
    expect_lit("clear_outputs", dut_vec, 10'h000);
    expect_lit("clear_keys", key_state, 10'h000);
    idle(3);
    send(8'h1D);
    expect_lit("post_clear_make", {8'h0, p1_ymov, p1_ydir}, 10'b10);

    // Randomized byte stream with occasional long gaps, clears and resets.
    for (int n = 0; n < 2500; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r == 0)      step(0, 8'h00, 0, 1);
      else if (r == 1) step(1, pool[$urandom_range(0, 15)], 1, 0);
      else             step(1, pool[$urandom_range(0, 15)], 0, 0);
      if ($urandom_range(0, 19) == 0) idle(T + 3);
      else                            idle(int'($urandom_range(0, 4)));
    end

    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_player_input.md
Name: ps2_player_input

Overview:
- Converts the PS/2 keyboard byte stream (set-2 scancodes) into the per-player movement and bomb signals consumed by bomberman_datapath: p1/p2 xdir, xmov, ydir, ymov and bomb.
- Sits directly upstream of the datapath, between the PS/2 receiver (one byte plus a valid strobe) and the game datapath/control.
- Tracks make/break/extended prefixes, holds a pressed-state bit per key, resolves opposing directions and emits single-cycle bomb pulses.

Parameters:
- TIMEOUT_CYCLES, 2500000, clock cycles allowed between a prefix byte (E0/F0) and its code byte before the prefix is discarded (50 ms at 50 MHz).
- TO_W, 22, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-high reset.
- ps2_byte  input  8  received scancode byte; sampled only when ps2_byte_valid=1.
- ps2_byte_valid  input  1  one-cycle strobe, one per received byte.
- clear  input  1  from control; releases all keys and returns the FSM to IDLE.
- p1_xdir, p1_xmov, p1_ydir, p1_ymov  output  1 each  P1 movement; dir 1 = increasing coordinate (right/down).
- p1_bomb  output  1  one-cycle pulse on a fresh P1 bomb-key make.
- p2_xdir, p2_xmov, p2_ydir, p2_ymov, p2_bomb  output  1 each  same as P1, for P2.
- key_state  output  10  held bits {p2_bomb,p2_R,p2_L,p2_D,p2_U,p1_bomb,p1_R,p1_L,p1_D,p1_U}, bit 0 = p1_U.

Behaviour:
- Key map:
  - P1, non-extended only: W=1D up, S=1B down, A=1C left, D=23 right, Space=29 bomb.
  - P2: extended only, E0 75 up, E0 72 down, E0 6B left, E0 74 right; Enter=5A (non-extended) bomb.
  - A code with the wrong extended-ness is ignored.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on edges where ps2_byte_valid=1.
  - IDLE: E0 -> EXT; F0 -> BRK; other byte -> apply make(code, ext=0), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> apply make(code, ext=1) -> IDLE.
  - BRK: any byte -> apply break(code, ext=0) -> IDLE.
  - EXT_BRK: any byte -> apply break(code, ext=1) -> IDLE.
  - E1, AA, FA, FC, EE and unmapped codes are ignored: no state-bit change, FSM returns to IDLE (or stays IDLE).
- make sets the key's held bit; break clears it. A repeated make on a held key (typematic) changes nothing.
- Bomb pulse: p1_bomb/p2_bomb = 1 for exactly the one cycle after the edge on which a bomb make is applied and that key's held bit was 0. Otherwise 0.
- Movement (registered, derived from held bits):
  - xmov = L XOR R; xdir = R & ~L.
  - ymov = U XOR D; ydir = D & ~U.
  - Both opposing keys held -> mov=0, dir=0.
- Latency: outputs reflect a completed sequence one clock after the edge that samples its final byte.
- Timeout: a counter starts at 0 on entering EXT, BRK or EXT_BRK and increments each cycle without valid. If it reaches TIMEOUT_CYCLES-1 without a byte, the FSM -> IDLE with no key change. The counter is held at 0 in IDLE.
- clear: at the next edge all held bits and all outputs = 0, FSM -> IDLE, counter = 0. clear takes priority over a simultaneous ps2_byte_valid, and that byte is discarded.
- reset: same effect as clear, and has the highest priority. It is synchronous, so mid-sequence prefixes are lost.
- Reset values: every output 0, key_state=0, FSM=IDLE.

Test Plan:
- Bytes 1D, then 23 (one per 10 cycles):
  - after 1D: p1_ymov=1, p1_ydir=0.
  - after 23: p1_xmov=1, p1_xdir=1.
  - F0 1D, then F0 23 -> all P1 movement outputs 0; key_state=0.
- Bytes E0 6B, then E0 74 -> p2_xmov=0, p2_xdir=0. Then E0 F0 6B -> p2_xmov=1, p2_xdir=1. No P1 output changes throughout.
- Bytes 29, 29, 29 (typematic), then F0 29, then 29 -> p1_bomb pulses exactly twice, each 1 cycle wide.
- Byte 75 without prefix -> no change. Byte 5A -> p2_bomb pulse, key_state[9]=1.
- Byte E0, then no byte for TIMEOUT_CYCLES cycles, then 75 -> FSM back in IDLE before 75 arrives; 75 is ignored and p2_ymov stays 0.
- Hold 1D and E0 72, then assert clear in the same cycle as a valid byte F0 -> next cycle all outputs 0 and key_state=0. A subsequent 1D is treated as a make (p1_ymov=1), not a break.
